// File: rtl/sort_ctrl8.sv
// Block bubble sorter: loads DEPTH words, sorts in place with one shared compare per cycle, streams them out.
// Build with SORT_DESCEND_EN defined for non-increasing output; the default build sorts non-decreasing.
module sort_ctrl8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iData,
  output logic             oReady,
  output logic             oValid,
  output logic [WIDTH-1:0] oData,
  input  logic             iReady,
  output logic             oBusy,
  output logic [2:0]       oCmp
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] JEND = PW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] j, j_nxt;
  logic [PW-1:0] pass, pass_nxt;
  logic          swapped, swapped_nxt;
  logic [2:0]    cmp_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    j_p1;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       cmp_res;
  logic             swap_now;
  logic             swapped_any;

  assign j_p1 = j + PW'(1);
  assign a    = mem[j];
  assign b    = mem[j_p1];

  // One-hot compare encoding: 100 a>b, 010 a<b, 001 equal.
  always_comb begin
    cmp_res = 3'b001;
    if (a > b)
      cmp_res = 3'b100;
    else if (a < b)
      cmp_res = 3'b010;
  end

`ifdef SORT_DESCEND_EN
  assign swap_now = cmp_res[1];
`else
  assign swap_now = cmp_res[2];
`endif

  assign swapped_any = swapped | swap_now;

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    j_nxt       = j;
    pass_nxt    = pass;
    swapped_nxt = swapped;
    cmp_nxt     = oCmp;
    case (state)
      LOAD: begin
        if (iValid) begin
          if (wr_ptr == LAST) begin
            state_nxt   = SORT;
            j_nxt       = '0;
            pass_nxt    = '0;
            swapped_nxt = 1'b0;
          end else begin
            wr_ptr_nxt = wr_ptr + PW'(1);
          end
        end
      end
      SORT: begin
        cmp_nxt = cmp_res;
        if (j != JEND) begin
          j_nxt       = j_p1;
          swapped_nxt = swapped_any;
        end else if (!swapped_any || pass == JEND) begin
          // A swap-free pass means the block is already ordered.
          state_nxt  = OUT;
          rd_ptr_nxt = '0;
        end else begin
          pass_nxt    = pass + PW'(1);
          j_nxt       = '0;
          swapped_nxt = 1'b0;
        end
      end
      OUT: begin
        if (iReady) begin
          if (rd_ptr == LAST) begin
            state_nxt  = LOAD;
            wr_ptr_nxt = '0;
          end else begin
            rd_ptr_nxt = rd_ptr + PW'(1);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= LOAD;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      j       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      oCmp    <= 3'b000;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      j       <= j_nxt;
      pass    <= pass_nxt;
      swapped <= swapped_nxt;
      oCmp    <= cmp_nxt;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge iClk) begin
    if (state == LOAD && iValid) begin
      mem[wr_ptr] <= iData;
    end else if (state == SORT && swap_now) begin
      mem[j]    <= b;
      mem[j_p1] <= a;
    end
  end

  assign oReady = (state == LOAD);
  assign oValid = (state == OUT);
  assign oBusy  = (state == SORT);
  assign oData  = (state == OUT) ? mem[rd_ptr] : '0;

endmodule
